// File: rtl/issue_scoreboard.sv
// Single-entry issue stage: holds one fetched instruction, blocks it on
// RAW hazards against per-register write countdowns and on unresolved branches.
module issue_scoreboard #(
  parameter int WB_LATENCY = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_instr,
  input  logic        out_ready,
  input  logic        br_resolved,
  input  logic        br_flush,
  output logic [15:0] busy_mask,
  output logic        stalled
);

  localparam int NREGS = 16;
  localparam int CW    = $clog2(WB_LATENCY + 1);

  logic [15:0]   hold_q, hold_d;
  logic          full_q, full_d;
  logic          blk_q, blk_d;
  logic [CW-1:0] cnt_q [NREGS];
  logic [CW-1:0] cnt_d [NREGS];

  logic [NREGS-1:0] busy;
  logic [3:0] op, rd, ra, rb;
  logic use_ra, use_rb, use_rd, wr, br;
  logic hazard, issue, flush, accept;

  assign op = hold_q[15:12];
  assign rd = hold_q[11:8];
  assign ra = hold_q[7:4];
  assign rb = hold_q[3:0];

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      busy[i] = (cnt_q[i] != '0);
    end
  end

  always_comb begin
    use_ra = 1'b0;
    use_rb = 1'b0;
    use_rd = 1'b0;
    wr     = 1'b0;
    br     = 1'b0;
    unique case (1'b1)
      (op >= 4'd1 && op <= 4'd8): begin
        use_ra = 1'b1;
        use_rb = 1'b1;
        wr     = 1'b1;
      end
      (op == 4'd9): begin
        use_ra = 1'b1;
        wr     = 1'b1;
      end
      (op == 4'd10): begin
        use_ra = 1'b1;
        use_rd = 1'b1;
      end
      (op == 4'd11): wr = 1'b1;
      (op == 4'd12 || op == 4'd14): begin
        use_ra = 1'b1;
        use_rd = 1'b1;
        br     = 1'b1;
      end
      (op == 4'd13): br = 1'b1;
      default: ;
    endcase
  end

  assign hazard = full_q & ((use_ra & busy[ra])
                          | (use_rb & busy[rb])
                          | (use_rd & busy[rd]));

  assign out_valid = full_q & ~hazard & ~blk_q;
  assign issue     = out_valid & out_ready;
  // A resolve with nothing outstanding is ignored, flush included.
  assign flush     = br_resolved & br_flush & blk_q;
  assign in_ready  = (~full_q | issue) & ~flush;
  assign accept    = in_valid & in_ready;

  assign out_instr = hold_q;
  assign busy_mask = busy;
  assign stalled   = full_q & ~out_valid;

  always_comb begin
    hold_d = accept ? in_instr : hold_q;
    full_d = full_q;
    if (accept) begin
      full_d = 1'b1;
    end else if (issue | flush) begin
      full_d = 1'b0;
    end
    blk_d = blk_q;
    if (issue & br) begin
      blk_d = 1'b1;
    end else if (br_resolved) begin
      blk_d = 1'b0;
    end
  end

  // A fresh mark wins over the decrement of the same register.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
      if (issue && wr && rd == 4'(i)) begin
        cnt_d[i] = CW'(WB_LATENCY);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
      blk_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
      blk_q  <= blk_d;
      for (int i = 0; i < NREGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: expected issues queued at accept,
// popped by a negedge monitor; issue cycles logged for latency checks.
module tb_issue_scoreboard;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_instr;
  logic        out_ready = 1'b0;
  logic        br_resolved = 1'b0;
  logic        br_flush = 1'b0;
  logic [15:0] busy_mask;
  logic        stalled;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  int iss_cyc[$];

  issue_scoreboard #(.WB_LATENCY(3)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_instr(in_instr),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_ready(out_ready),
    .br_resolved(br_resolved),
    .br_flush(br_flush),
    .busy_mask(busy_mask),
    .stalled(stalled)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      iss_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", {16'h0, out_instr}, 32'hffff_ffff);
      end else begin
        chk("issue_instr", {16'h0, out_instr}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(logic [15:0] ins, bit will_issue);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clock);
      if (in_ready) begin
        done = 1'b1;
        if (will_issue) exp_q.push_back(ins);
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
    chk("drain", exp_q.size(), 0);
  endtask

  function automatic int gap();
    if (iss_cyc.size() < 2) return -1;
    return iss_cyc[1] - iss_cyc[0];
  endfunction

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_stalled", stalled, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Mid-traffic reset with a stalled consumer held
    out_ready = 1'b1;
    send(16'h8123, 1'b1);
    send(16'h1214, 1'b1);
    chk("pre_rst_busy", busy_mask, 16'h0002);
    chk("pre_rst_stalled", stalled, 1);
    reset_n = 1'b0;
    #1;
    chk("t1_in_ready", in_ready, 1);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_busy", busy_mask, 0);
    chk("t1_stalled", stalled, 0);
    exp_q.delete();
    in_valid = 1'b1;
    in_instr = 16'h8999;
    repeat (2) begin
      @(negedge clock);
      chk("t1_no_issue", out_valid, 0);
    end
    #1;
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // T2 RAW stall
    iss_cyc.delete();
    send(16'h8123, 1'b1);
    send(16'h1214, 1'b1);
    chk("t2_busy1", busy_mask, 16'h0002);
    chk("t2_stall1", stalled, 1);
    tick();
    chk("t2_busy2", busy_mask, 16'h0002);
    tick();
    chk("t2_busy3", busy_mask, 16'h0002);
    drain();
    chk("t2_gap", gap(), 4);
    repeat (5) tick();

    // T3 independent back-to-back
    iss_cyc.delete();
    send(16'h8123, 1'b1);
    send(16'h8456, 1'b1);
    tick();
    chk("t3_busy", busy_mask, 16'h0012);
    drain();
    chk("t3_gap", gap(), 1);
    repeat (5) tick();

    // T4 branch then flush of wrong-path instruction
    send(16'hC120, 1'b1);
    send(16'h8000, 1'b0);
    repeat (2) begin
      chk("t4_blocked", out_valid, 0);
      chk("t4_held", out_instr, 16'h8000);
      chk("t4_stalled", stalled, 1);
      tick();
    end
    br_resolved = 1'b1;
    br_flush = 1'b1;
    #1;
    chk("t4_flush_in_ready", in_ready, 0);
    tick();
    br_resolved = 1'b0;
    br_flush = 1'b0;
    chk("t4_empty", stalled, 0);
    chk("t4_in_ready", in_ready, 1);
    send(16'h8311, 1'b1);
    drain();
    repeat (5) tick();

    // T5 backpressure; stray flush without a branch is ignored
    out_ready = 1'b0;
    send(16'hB305, 1'b1);
    for (int k = 0; k < 5; k++) begin
      br_resolved = (k == 2);
      br_flush = (k == 2);
      #1;
      chk("t5_valid", out_valid, 1);
      chk("t5_instr", out_instr, 16'hB305);
      chk("t5_in_ready", in_ready, 0);
      tick();
    end
    br_resolved = 1'b0;
    br_flush = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_busy", busy_mask, 16'h0008);
    tick();
    tick();
    chk("t5_busy_last", busy_mask, 16'h0008);
    tick();
    chk("t5_busy_clear", busy_mask, 0);

    // T6 store waits on load destination
    iss_cyc.delete();
    send(16'h9700, 1'b1);
    send(16'hA710, 1'b1);
    drain();
    chk("t6_gap", gap(), 4);
    repeat (5) tick();

    // Resolve landing on the jump's issue cycle keeps the block
    send(16'hD000, 1'b1);
    br_resolved = 1'b1;
    tick();
    br_resolved = 1'b0;
    send(16'h0000, 1'b1);
    chk("jmp_blocked", out_valid, 0);
    chk("jmp_stalled", stalled, 1);
    br_resolved = 1'b1;
    tick();
    br_resolved = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
